goto_rep_monitor: RTL

//   Synthesizable monitor for the rule "trig_i |-> evt_i[->N_HITS]", with optional "##1 done_i".

---
 rtl/goto_rep_monitor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/goto_rep_monitor.sv
// Single-thread monitor for "trig_i |-> evt_i[->N_HITS] (##1 done_i)" with registered
// pass/fail pulses and saturating pass/fail/drop statistics.
module goto_rep_monitor #(
  parameter int unsigned N_HITS   = 3,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trig_i,
  input  logic                         evt_i,
  input  logic                         done_i,
  input  logic                         chk_c_en_i,
  output logic                         busy_o,
  output logic [$clog2(N_HITS+1)-1:0]  hit_cnt_o,
  output logic                         pass_o,
  output logic                         fail_o,
  output logic [CNT_W-1:0]             pass_cnt_o,
  output logic [CNT_W-1:0]             fail_cnt_o,
  output logic [CNT_W-1:0]             drop_cnt_o
);

  localparam int unsigned HIT_W  = $clog2(N_HITS + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    WAIT_C = 2'd2
  } state_t;

  state_t              state;
  logic                chk_c;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_nxt;
  logic                last_hit;

  assign wait_nxt = wait_cnt + WAIT_W'(1);
  assign last_hit = evt_i && (hit_cnt_o == HIT_W'(N_HITS - 1));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Attempt FSM; the deciding edge registers the pulse and returns to IDLE together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      chk_c      <= 1'b0;
      wait_cnt   <= '0;
      busy_o     <= 1'b0;
      hit_cnt_o  <= '0;
      pass_o     <= 1'b0;
      fail_o     <= 1'b0;
      pass_cnt_o <= '0;
      fail_cnt_o <= '0;
      drop_cnt_o <= '0;
    end else begin
      pass_o <= 1'b0;
      fail_o <= 1'b0;
      if (state != IDLE && trig_i) begin
        drop_cnt_o <= sat_inc(drop_cnt_o);
      end
      case (state)
        IDLE: begin
          hit_cnt_o <= '0;
          busy_o    <= 1'b0;
          if (trig_i) begin
            chk_c     <= chk_c_en_i;
            wait_cnt  <= '0;
            hit_cnt_o <= HIT_W'(evt_i);
            if (evt_i && N_HITS == 1) begin
              if (chk_c_en_i) begin
                state  <= WAIT_C;
                busy_o <= 1'b1;
              end else begin
                pass_o     <= 1'b1;
                pass_cnt_o <= sat_inc(pass_cnt_o);
              end
            end else begin
              state  <= COUNT;
              busy_o <= 1'b1;
            end
          end
        end
        COUNT: begin
          wait_cnt <= wait_nxt;
          if (evt_i) begin
            hit_cnt_o <= hit_cnt_o + HIT_W'(1);
          end
          if (last_hit) begin
            if (chk_c) begin
              state <= WAIT_C;
            end else begin
              state      <= IDLE;
              busy_o     <= 1'b0;
              pass_o     <= 1'b1;
              pass_cnt_o <= sat_inc(pass_cnt_o);
            end
          end else if (wait_nxt >= WAIT_W'(MAX_WAIT - 1)) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            fail_o     <= 1'b1;
            fail_cnt_o <= sat_inc(fail_cnt_o);
          end
        end
        WAIT_C: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          if (done_i) begin
            pass_o     <= 1'b1;
            pass_cnt_o <= sat_inc(pass_cnt_o);
          end else begin
            fail_o     <= 1'b1;
            fail_cnt_o <= sat_inc(fail_cnt_o);
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
